// File: rtl/dmem_store_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory request path.
package dmem_store_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned MBE_W = 4;
  localparam int unsigned OFF_W = 2;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_t;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dmem_state_t;

  // Request payload held toward the data cache for the whole access
  typedef struct packed {
    logic             read;
    logic             write;
    logic [XLEN-1:0]  address;
    logic [XLEN-1:0]  wdata;
    logic [MBE_W-1:0] mbe;
    logic [OFF_W-1:0] byte_off;
  } dmem_req_t;

endpackage

// File: rtl/dmem_store_ctrl_store_align.sv
// Byte-mask, lane-shifted write data and alignment fault for one access.
module store_align
  import dmem_store_ctrl_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic [2:0]       funct3,
  input  mem_op_t          mem_op,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  rs2_out,
  output logic [MBE_W-1:0] mbe,
  output logic [XLEN-1:0]  wdata,
  output logic             bad
);

  always_comb begin
    mbe   = '1;
    bad   = 1'b0;
    wdata = rs2_out << {off, 3'b000};
    if (mem_op == MEM_STORE) begin
      case (funct3)
        F3_SB:   mbe = MBE_W'(4'b0001) << off;
        F3_SH: begin
          mbe = MBE_W'(4'b0011) << off;
          bad = off[0];
        end
        default: bad = (off != 2'b00);
      endcase
    end else if (mem_op == MEM_LOAD) begin
      // Only word loads fault; sub-word extraction happens in writeback
      bad = (funct3 == F3_SW) && (off != 2'b00);
    end
    if (!ALIGN_CHECK) bad = 1'b0;
  end

endmodule

// File: rtl/dmem_store_ctrl.sv
// MEM-stage data-cache request controller: issues one load/store, stalls until response.
module dmem_store_ctrl
  import dmem_store_ctrl_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_mem,
  input  mem_op_t          mem_op,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [XLEN-1:0]  rs2_out,
  input  logic             pipe_adv,
  input  logic             dmem_resp,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [XLEN-1:0]  dmem_address,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [MBE_W-1:0] dmem_mbe,
  output logic             mem_stall,
  output logic [XLEN-1:0]  rdata_mem,
  output logic [OFF_W-1:0] byte_off,
  output logic             misaligned
);

  dmem_state_t      state_q, state_d;
  dmem_req_t        req_q, req_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic [MBE_W-1:0] mbe_c;
  logic [XLEN-1:0]  wdata_c;
  logic             bad_c;
  logic             need_access;

  store_align #(.ALIGN_CHECK(ALIGN_CHECK)) u_align (
    .funct3  (funct3),
    .mem_op  (mem_op),
    .off     (alu_out[1:0]),
    .rs2_out (rs2_out),
    .mbe     (mbe_c),
    .wdata   (wdata_c),
    .bad     (bad_c)
  );

  assign need_access = valid_mem && (mem_op != MEM_NONE) && !bad_c;

  // Next state, next request payload and the combinational stall/fault flags
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    mem_stall  = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      IDLE: begin
        if (need_access) begin
          req_d.read     = (mem_op == MEM_LOAD);
          req_d.write    = (mem_op == MEM_STORE);
          req_d.address  = {alu_out[XLEN-1:2], 2'b00};
          req_d.wdata    = wdata_c;
          req_d.mbe      = mbe_c;
          req_d.byte_off = alu_out[1:0];
          mem_stall      = 1'b1;
          state_d        = BUSY;
        end else if (valid_mem && bad_c) begin
          misaligned = 1'b1;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dmem_resp) begin
          if (req_q.read) rdata_d = dmem_rdata;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Wait for MEM/WB to take the result so the access is never reissued
        if (pipe_adv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_read    = req_q.read;
  assign dmem_write   = req_q.write;
  assign dmem_address = req_q.address;
  assign dmem_wdata   = req_q.wdata;
  assign dmem_mbe     = req_q.mbe;
  assign byte_off     = req_q.byte_off;
  assign rdata_mem    = rdata_q;

endmodule

// File: doc/dmem_store_ctrl.md
Name: dmem_store_ctrl

Overview:
- MEM-stage data-memory request controller for the rv32i pipeline.
- Issues load reads and sb/sh/sw writes to the data cache port, and generates the byte mask and lane-shifted store data.
- Holds the request until the cache responds and stalls the pipeline while the access is outstanding.
- Hands the raw read word and the byte offset to MEM/WB, where writeback does load extraction and extension.

Parameters:
- ALIGN_CHECK, 1, when 1, misaligned accesses are suppressed (no request, flag raised); when 0, the address is word-aligned and the access proceeds.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- valid_mem  in  1  instruction in MEM is valid
- mem_op  in  2  from rv32i_types: none=00, load=01, store=10
- funct3  in  3  store width: sb=000, sh=001, sw=010 (ignored for loads)
- alu_out  in  32  effective address
- rs2_out  in  32  store source data
- pipe_adv  in  1  MEM/WB register loads this cycle (hazard unit)
- dmem_resp  in  1  cache response strobe
- dmem_rdata  in  32  cache read word
- dmem_read  out  1  read request, registered
- dmem_write  out  1  write request, registered
- dmem_address  out  32  {alu_out[31:2],2'b00}, registered
- dmem_wdata  out  32  lane-shifted store data, registered
- dmem_mbe  out  4  byte mask, registered
- mem_stall  out  1  freeze IF..MEM
- rdata_mem  out  32  captured read word for MEM/WB
- byte_off  out  2  alu_out[1:0] of the current access
- misaligned  out  1  current access suppressed

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; dmem_read, dmem_write, misaligned = 0; dmem_address, dmem_wdata, rdata_mem = 0; dmem_mbe = 0; byte_off = 0. Reset mid-access abandons the request. Any later dmem_resp arriving in IDLE is ignored.
- need_access = valid_mem & mem_op != none & ~bad.
- bad (ALIGN_CHECK=1):
  - sw with off != 00
  - sh with off[0] = 1
  - load with off != 00 only if funct3 is lw; loads carry funct3 too
- Byte mask:
  - sb: 0001 << off
  - sh: 0011 << off
  - sw and loads: 1111
- Write data: rs2_out << (8*off); unused lanes zero.
- State IDLE:
  - If need_access: register address, wdata, mbe and byte_off; set dmem_read or dmem_write; go to BUSY.
  - mem_stall is combinationally 1 in that cycle.
  - If valid_mem & bad: misaligned = 1 combinationally, no request, no stall.
- State BUSY:
  - Request outputs held stable; mem_stall = 1.
  - On dmem_resp: on the same edge, clear dmem_read and dmem_write; capture dmem_rdata into rdata_mem (loads only; stores leave rdata_mem unchanged); go to DONE.
  - dmem_resp in the same cycle as the request is first driven is impossible, since the request is registered. The minimum latency is request edge +1.
- State DONE:
  - mem_stall = 0; outputs of the completed access stay visible.
  - On pipe_adv, go to IDLE. The next instruction is evaluated in the following cycle, so one access is never issued twice.
  - If pipe_adv is low (downstream stall), remain in DONE and issue no request.
- Stores complete with dmem_resp only; write-through ordering is the cache's responsibility.
- pipe_adv in IDLE or BUSY has no effect on state.
- Best case, one load/store costs 2 stall cycles (issue, resp).

Decomposition:
- rv32i_types gains:
  - enum mem_op_t {none, load, store}
  - store_funct3 constants sb/sh/sw
  - dmem_state_t {IDLE, BUSY, DONE}
- One combinational sub-module, store_align, maps (funct3, mem_op, off, rs2_out) to (mbe, wdata, bad). It is shared with future writeback-side checks.

Test Plan:
- sw at 0x0000_1000 with rs2=0xCAFEBABE:
  - Next cycle: dmem_write=1, addr 0x1000, mbe 1111, wdata 0xCAFEBABE.
  - Resp after 3 cycles: mem_stall high for 4 cycles, then low.
- sb at 0x1003 with rs2=0x000000A5 → mbe 1000, wdata 0xA5000000, addr 0x1000.
- sh at 0x1002 with rs2=0x1234 → mbe 1100, wdata 0x12340000. sh at 0x1001 → misaligned=1, no request, mem_stall=0.
- lw at 0x2004, resp carries 0xDEADBEEF:
  - rdata_mem = 0xDEADBEEF, byte_off = 00.
  - Holding pipe_adv=0 for 5 cycles in DONE: no second dmem_read.
- rst=0 while in BUSY:
  - Next edge: dmem_read=0 and state IDLE.
  - A dmem_resp one cycle later is ignored; rdata_mem stays 0.
- Back-to-back sw then lw with pipe_adv pulsing in DONE → two distinct requests, separated by at least one idle cycle.
